// File: rtl/fpdiv_pkg.sv
// fpdiv_pkg: shared constants for the Goldschmidt divider controller family.
//   State codes for the sequencer, datapath mux select codes, and the IEEE-754
//   single-precision constants used by the special-operand classifier.
package fpdiv_pkg;

  localparam int ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [ST_W-1:0] ST_INIT_A = 3'd1;
  localparam logic [ST_W-1:0] ST_INIT_B = 3'd2;
  localparam logic [ST_W-1:0] ST_ITER_A = 3'd3;
  localparam logic [ST_W-1:0] ST_ITER_B = 3'd4;
  localparam logic [ST_W-1:0] ST_REM    = 3'd5;
  localparam logic [ST_W-1:0] ST_ROUND  = 3'd6;
  localparam logic [ST_W-1:0] ST_DONE   = 3'd7;

  // mux3 feeds the multiplier's second operand, mux4 its first
  localparam logic [1:0] M3_IA    = 2'd0;
  localparam logic [1:0] M3_REGC  = 2'd1;
  localparam logic [1:0] M3_DENOM = 2'd2;

  localparam logic [1:0] M4_NUM   = 2'd0;
  localparam logic [1:0] M4_DENOM = 2'd1;
  localparam logic [1:0] M4_REGA  = 2'd2;
  localparam logic [1:0] M4_REGB  = 2'd3;

  localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
  localparam logic [7:0]  FP_INF_EXP = 8'hFF;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       en_a;
    logic       en_b;
    logic       en_rem;
    logic [1:0] sel_mux3;
    logic [1:0] sel_mux4;
  } ctrl_t;

endpackage

// File: rtl/fpdiv_special.sv
// fpdiv_special: combinational special-operand classifier for divide.
//   a, b         in  32  IEEE single operands
//   is_special   out 1   operands bypass the datapath
//   special_val  out 32  quotient to return when is_special
// Denormals (exponent field 0) are treated as zero.
module fpdiv_special
  import fpdiv_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        is_special,
  output logic [31:0] special_val
);

  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sgn;

  always_comb begin
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    a_inf  = (a[30:23] == FP_INF_EXP) && (a[22:0] == 23'h0);
    b_inf  = (b[30:23] == FP_INF_EXP) && (b[22:0] == 23'h0);
    a_nan  = (a[30:23] == FP_INF_EXP) && (a[22:0] != 23'h0);
    b_nan  = (b[30:23] == FP_INF_EXP) && (b[22:0] != 23'h0);
    sgn    = a[31] ^ b[31];
  end

  // Order matters: indeterminate forms win over infinity, infinity over zero.
  always_comb begin
    is_special  = 1'b1;
    special_val = 32'h0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      special_val = FP_QNAN;
    end else if (a_inf || b_zero) begin
      special_val = {sgn, FP_INF_EXP, 23'h0};
    end else if (a_zero || b_inf) begin
      special_val = {sgn, 31'h0};
    end else begin
      is_special = 1'b0;
    end
  end

endmodule

// File: rtl/fpdiv_ctrl.sv
// fpdiv_ctrl: sequencer for the single-multiplier Goldschmidt divider.
//   clk, reset (async, active-low)
//   start, a_in, b_in, rm_in      request and operands (sampled in IDLE/DONE)
//   busy, done, result, special   handshake and answer
//   dp_num, dp_denom, dp_rm       latched operands to datapath
//   en_a, en_b, en_rem            datapath register enables
//   sel_mux3, sel_mux4            datapath mux selects
//   dp_ans                        datapath rounded answer
//
// state  | meaning
// IDLE   | waiting for start
// INIT_A | rega <= num * initial approx
// INIT_B | regb/regc <= denom * initial approx
// ITER_A | rega <= rega * regc
// ITER_B | regb/regc <= regb * regc, count iteration
// REM    | remainder <= rega * denom
// ROUND  | capture dp_ans
// DONE   | done pulse; may accept next request
module fpdiv_ctrl
  import fpdiv_pkg::*;
#(
  parameter int ITERS = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  input  logic        rm_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        special,
  output logic [31:0] dp_num,
  output logic [31:0] dp_denom,
  output logic        dp_rm,
  output logic        en_a,
  output logic        en_b,
  output logic        en_rem,
  output logic [1:0]  sel_mux3,
  output logic [1:0]  sel_mux4,
  input  logic [31:0] dp_ans
);

  localparam int CNT_W = $clog2(ITERS) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

  logic [ST_W-1:0]  state;
  logic [CNT_W-1:0] iter_cnt;
  logic             is_special;
  logic [31:0]      special_val;
  ctrl_t            ctrl;

  // Classifies the live inputs so the special path resolves on the accept edge.
  fpdiv_special u_special (
    .a           (a_in),
    .b           (b_in),
    .is_special  (is_special),
    .special_val (special_val)
  );

  always_comb begin
    ctrl = '0;
    case (state)
      ST_INIT_A: begin
        ctrl.busy = 1'b1; ctrl.en_a = 1'b1;
        ctrl.sel_mux3 = M3_IA;    ctrl.sel_mux4 = M4_NUM;
      end
      ST_INIT_B: begin
        ctrl.busy = 1'b1; ctrl.en_b = 1'b1;
        ctrl.sel_mux3 = M3_IA;    ctrl.sel_mux4 = M4_DENOM;
      end
      ST_ITER_A: begin
        ctrl.busy = 1'b1; ctrl.en_a = 1'b1;
        ctrl.sel_mux3 = M3_REGC;  ctrl.sel_mux4 = M4_REGA;
      end
      ST_ITER_B: begin
        ctrl.busy = 1'b1; ctrl.en_b = 1'b1;
        ctrl.sel_mux3 = M3_REGC;  ctrl.sel_mux4 = M4_REGB;
      end
      ST_REM: begin
        ctrl.busy = 1'b1; ctrl.en_rem = 1'b1;
        ctrl.sel_mux3 = M3_DENOM; ctrl.sel_mux4 = M4_REGA;
      end
      ST_ROUND: ctrl.busy = 1'b1;
      ST_DONE:  ctrl.done = 1'b1;
      default:  ctrl = '0;
    endcase
  end

  assign busy     = ctrl.busy;
  assign done     = ctrl.done;
  assign en_a     = ctrl.en_a;
  assign en_b     = ctrl.en_b;
  assign en_rem   = ctrl.en_rem;
  assign sel_mux3 = ctrl.sel_mux3;
  assign sel_mux4 = ctrl.sel_mux4;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      iter_cnt <= '0;
      dp_num   <= 32'h0;
      dp_denom <= 32'h0;
      dp_rm    <= 1'b0;
      result   <= 32'h0;
      special  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            dp_num   <= a_in;
            dp_denom <= b_in;
            dp_rm    <= rm_in;
            if (is_special) begin
              result  <= special_val;
              special <= 1'b1;
              state   <= ST_DONE;
            end else begin
              state <= ST_INIT_A;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_INIT_A: state <= ST_INIT_B;
        ST_INIT_B: begin
          iter_cnt <= '0;
          state    <= ST_ITER_A;
        end
        ST_ITER_A: state <= ST_ITER_B;
        ST_ITER_B: begin
          if (iter_cnt == CNT_LAST) begin
            state <= ST_REM;
          end else begin
            iter_cnt <= iter_cnt + CNT_W'(1);
            state    <= ST_ITER_A;
          end
        end
        ST_REM: state <= ST_ROUND;
        ST_ROUND: begin
          result  <= dp_ans;
          special <= 1'b0;
          state   <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
